// File: rtl/lab2_proc_imul_pkg.sv
// ============================================================================
// Module   : lab2_proc_imul_pkg
// Purpose  : Shared types and constants for the iterative integer multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lab2_proc_imul_pkg;

    localparam int c_imul_nbits = 32;
    localparam int c_imul_cnt_w = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } imul_state_e;

    typedef struct packed {
        logic [c_imul_nbits-1:0] a;
        logic [c_imul_nbits-1:0] b;
    } imul_req_t;

endpackage

`default_nettype wire

// File: rtl/lab2_proc_imul_iter_dpath.sv
// ============================================================================
// Module   : lab2_proc_imul_iter_dpath
// Purpose  : Shift-add datapath: operand shifters, accumulator and adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab2_proc_imul_iter_dpath #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [p_nbits-1:0] a_in,
    input  logic [p_nbits-1:0] b_in,
    output logic [p_nbits-1:0] result,
    output logic               b_lsb,
    output logic               b_is_zero
);

    logic [p_nbits-1:0] a_reg_q, a_reg_d;
    logic [p_nbits-1:0] b_reg_q, b_reg_d;
    logic [p_nbits-1:0] result_reg_q, result_reg_d;

    always_comb begin
        a_reg_d      = a_reg_q;
        b_reg_d      = b_reg_q;
        result_reg_d = result_reg_q;
        if (load) begin
            a_reg_d      = a_in;
            b_reg_d      = b_in;
            result_reg_d = '0;
        end else if (step) begin
            // Carry out of the accumulator is dropped: only the low bits matter.
            if (b_reg_q[0]) begin
                result_reg_d = result_reg_q + a_reg_q;
            end
            a_reg_d = a_reg_q << 1;
            b_reg_d = b_reg_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg_q      <= '0;
            b_reg_q      <= '0;
            result_reg_q <= '0;
        end else begin
            a_reg_q      <= a_reg_d;
            b_reg_q      <= b_reg_d;
            result_reg_q <= result_reg_d;
        end
    end

    assign result    = result_reg_q;
    assign b_lsb     = b_reg_q[0];
    // Looks one step ahead: true when this step's shift leaves b empty.
    assign b_is_zero = ((b_reg_q >> 1) == '0);

endmodule

`default_nettype wire

// File: rtl/lab2_proc_imul_iter.sv
// ============================================================================
// Module   : lab2_proc_imul_iter
// Purpose  : Iterative 32-bit multiplier (low product bits), val/rdy streams,
//            squashable via cancel. Optional macro LAB2_PROC_IMUL_EARLY_EXIT_EN
//            ends the loop once the remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab2_proc_imul_iter
    import lab2_proc_imul_pkg::*;
#(
    parameter int p_nbits = c_imul_nbits
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*p_nbits-1:0] req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [p_nbits-1:0]   resp_msg,
    input  logic                 cancel
);

    imul_state_e             state_q, state_d;
    logic [c_imul_cnt_w-1:0] count_q, count_d;
    logic                    load;
    logic                    step;
    logic                    calc_last;
    logic [p_nbits-1:0]      result;
    logic                    b_lsb;
    logic                    b_is_zero;
    logic                    unused_status;

`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
    assign calc_last     = (count_q == '1) || b_is_zero;
    assign unused_status = b_lsb;
`else
    assign calc_last     = (count_q == '1);
    assign unused_status = b_lsb ^ b_is_zero;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load     = 1'b0;
        step     = 1'b0;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = !cancel;
                if (req_val && !cancel) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step    = 1'b1;
                count_d = count_q + 1'b1;
                if (calc_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_val = !cancel;
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A squash overrides any handshake in the same cycle.
        if (cancel) begin
            state_d = IDLE;
        end
        if (!reset) begin
            req_rdy  = 1'b0;
            resp_val = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    lab2_proc_imul_iter_dpath #(
        .p_nbits (p_nbits)
    ) u_dpath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .a_in      (req_msg[2*p_nbits-1:p_nbits]),
        .b_in      (req_msg[p_nbits-1:0]),
        .result    (result),
        .b_lsb     (b_lsb),
        .b_is_zero (b_is_zero)
    );

    assign resp_msg = resp_val ? result : '0;

endmodule

`default_nettype wire

// File: tb/tb_lab2_proc_imul_iter.sv
// ============================================================================
// Module   : tb_lab2_proc_imul_iter
// Purpose  : Self-checking bench for lab2_proc_imul_iter (vector table plus
//            directed multi-cycle sequences, scoreboard queue for results).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lab2_proc_imul_iter;
    import lab2_proc_imul_pkg::*;

    localparam int NB   = 32;
    localparam int NVEC = 13;

    logic            clk      = 1'b0;
    logic            reset    = 1'b0;
    logic            req_val  = 1'b0;
    logic            req_rdy;
    logic [2*NB-1:0] req_msg  = '0;
    logic            resp_val;
    logic            resp_rdy = 1'b0;
    logic [NB-1:0]   resp_msg;
    logic            cancel   = 1'b0;

    int              chk_cnt  = 0;
    int              pass_cnt = 0;
    logic [NB-1:0]   sb_q[$];

    typedef struct {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic [NB-1:0] exp;
    } vec_t;

    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    lab2_proc_imul_iter #(
        .p_nbits (NB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg),
        .cancel   (cancel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [NB-1:0] b);
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
        int k = 0;
        for (int i = 0; i < NB; i++) begin
            if (b[i]) k = i;
        end
        return k + 2;
`else
        return 33;
`endif
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1 after the accept.
    task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input logic [NB-1:0] exp, input bit push);
        imul_req_t r;
        int n = 0;
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_rdy_before_send", 32'(req_rdy), 32'd1);
        r.a = a;
        r.b = b;
        req_val = 1'b1;
        req_msg = r;
        if (push) sb_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        req_val = 1'b0;
        req_msg = '0;
    endtask

    task automatic wait_resp(input logic [NB-1:0] b);
        int lat = 1;
        while (!resp_val && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_val_seen", 32'(resp_val), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat(b)));
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            chk("resp_msg", resp_msg, sb_q.pop_front());
        end
    endtask

    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-1:0] exp);
        resp_rdy = 1'b1;
        send(a, b, exp, 1'b1);
        wait_resp(b);
        chk("req_rdy_in_resp_cycle", 32'(req_rdy), 32'd0);
        @(negedge clk);
        chk("resp_val_after_hs", 32'(resp_val), 32'd0);
        chk("req_rdy_after_hs", 32'(req_rdy), 32'd1);
    endtask

    task automatic expect_quiet(input int n, input string name);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (resp_val) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'd3,        32'd5,        32'd15};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[2]  = '{32'h80000000, 32'd2,        32'h00000000};
        vecs[3]  = '{32'd7,        32'd6,        32'd42};
        vecs[4]  = '{32'd0,        32'h12345678, 32'd0};
        vecs[5]  = '{32'h12345678, 32'd0,        32'd0};
        vecs[6]  = '{32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[7]  = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE};
        vecs[8]  = '{32'h00010000, 32'h00010000, 32'h00000000};
        vecs[9]  = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
        vecs[10] = '{32'h80000000, 32'd1,        32'h80000000};
        for (int i = 11; i < NVEC; i++) begin
            vecs[i].a   = $urandom;
            vecs[i].b   = $urandom;
            vecs[i].exp = vecs[i].a * vecs[i].b;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_req_rdy", 32'(req_rdy), 32'd0);
        chk("reset_resp_val", 32'(resp_val), 32'd0);
        chk("reset_resp_msg", resp_msg, 32'd0);
        reset = 1'b1;
        #1;
        chk("req_rdy_after_reset", 32'(req_rdy), 32'd1);
        @(negedge clk);

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Backpressure: DONE held, no accept while waiting
        resp_rdy = 1'b0;
        send(32'd6, 32'd7, 32'd42, 1'b1);
        wait_resp(32'd7);
        repeat (10) begin
            req_val = 1'b1;
            req_msg = {32'd9, 32'd9};
            @(negedge clk);
            chk("bp_resp_val", 32'(resp_val), 32'd1);
            chk("bp_resp_msg", resp_msg, 32'd42);
            chk("bp_req_rdy", 32'(req_rdy), 32'd0);
        end
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("bp_released_idle", 32'(req_rdy), 32'd1);
        expect_quiet(40, "bp_no_extra_resp");

        // Cancel in CALC cycle 10
        send(32'd9, 32'hFFFFFFFF, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        #1;
        chk("cancel_req_rdy", 32'(req_rdy), 32'd0);
        chk("cancel_resp_val", 32'(resp_val), 32'd0);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        chk("cancel_then_idle", 32'(req_rdy), 32'd1);
        expect_quiet(40, "cancel_no_resp");
        run_op(32'd7, 32'd6, 32'd42);

        // Cancel in IDLE blocks an accept
        req_val = 1'b1;
        req_msg = {32'd3, 32'd3};
        cancel  = 1'b1;
        #1;
        chk("cancel_idle_req_rdy", 32'(req_rdy), 32'd0);
        @(negedge clk);
        cancel  = 1'b0;
        req_val = 1'b0;
        req_msg = '0;
        #1;
        chk("cancel_idle_not_accepted", 32'(req_rdy), 32'd1);
        @(negedge clk);

        // Back-to-back
        run_op(32'd2, 32'd3, 32'd6);
        run_op(32'd4, 32'd5, 32'd20);

        // Reset in CALC cycle 5
        send(32'd11, 32'hFFFFFFFF, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_resp_val", 32'(resp_val), 32'd0);
        chk("midreset_req_rdy", 32'(req_rdy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_release_rdy", 32'(req_rdy), 32'd1);
        expect_quiet(40, "midreset_no_resp");
        run_op(32'd3, 32'd5, 32'd15);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lab2_proc_imul_iter.md
# lab2_proc_imul_iter

Iterative 32-bit integer multiplier serving the execute stage of the 5-stage pipelined processor. It implements the tinyrv2 `mul` instruction.

- The X stage sends two operands over a val/rdy request stream.
- The unit computes the low 32 bits of the product with a shift-add loop.
- The result returns over a val/rdy response stream, which the X-stage result mux then selects.
- Control can cancel an in-flight operation when the owning instruction is squashed.

## Interface
Parameters:
- p_nbits, 32, operand and result width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- req_val  input  1  request valid
- req_rdy  output  1  request ready; high only in IDLE
- req_msg  input  2*p_nbits  {a[63:32], b[31:0]} operands
- resp_val  output  1  result valid
- resp_rdy  input  1  consumer ready
- resp_msg  output  p_nbits  product low bits
- cancel  input  1  synchronous squash of any in-flight operation

## Operation
- Registers: a_reg (p_nbits), b_reg (p_nbits), result_reg (p_nbits), count (5 bits), state.
- Arithmetic:
  - Product is (a*b) mod 2^32.
  - Signed and unsigned operands give identical low bits, so there is no sign handling.
  - Carry out of result_reg is discarded.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - req_rdy=1 unless cancel=1.
  - On req_val&req_rdy: a_reg←a, b_reg←b, result_reg←0, count←0, go to CALC.
- CALC, each cycle:
  - If b_reg[0]: result_reg←result_reg+a_reg.
  - a_reg←a_reg<<1, b_reg←b_reg>>1 (logical), count←count+1.
  - Go to DONE when count==31.
- DONE:
  - resp_val=1 and resp_msg=result_reg.
  - On resp_val&resp_rdy go to IDLE.
  - Otherwise hold, with resp_msg stable.
- cancel=1 in any state:
  - next state IDLE; registers are don't-care.
  - req_rdy and resp_val are forced to 0 in the same cycle.
  - No handshake completes in a cancel cycle; cancel wins over a simultaneous accept or response.
- resp_msg is 0 whenever resp_val=0.

## Timing
- Reset (reset=0, asynchronous):
  - state←IDLE, all registers←0.
  - req_rdy=0, resp_val=0, resp_msg=0 while reset is asserted.
- After reset deasserts, req_rdy=1 in the first cycle.
- Request accepted at the end of cycle 0:
  - CALC occupies cycles 1–32.
  - resp_val is first high in cycle 33 (33-cycle latency in the base build).
- Throughput:
  - One operation in flight; req_rdy=0 from cycle 1 until the cycle after the response handshake.
  - No accept occurs in the same cycle as the response handshake.
- Backpressure: resp_rdy=0 holds DONE indefinitely with resp_val and resp_msg stable.
- Reset asserted mid-operation: immediate return to IDLE; the partial result is lost and no response is produced.
- resp_val and req_rdy are functions of state, cancel and reset only; there is no combinational path from req_val or resp_rdy.

## Configuration
- LAB2_PROC_IMUL_EARLY_EXIT_EN defined:
  - CALC exits to DONE in the cycle where the shifted b_reg becomes 0, or when count==31.
  - Latency becomes k+2 cycles to resp_val, where k is the index of b's highest set bit.
  - b=0 gives resp_val in cycle 2.
- Undefined: fixed 32 CALC cycles for every operand pair.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package lab2_proc_imul_pkg:
  - state enum {IDLE, CALC, DONE}
  - imul_req_t packed struct {a, b}
  - constant c_imul_nbits=32 and count width 5
- One sub-module, lab2_proc_imul_iter_dpath:
  - a_reg, b_reg, result_reg, the adder and the shifters
  - takes load/step enables from the FSM in the top level
  - returns b_lsb and b_is_zero status

## Test plan
- Reset then a=3, b=5, resp_rdy=1:
  - req_rdy=1 after reset.
  - resp_msg=15 with resp_val first high in cycle 33 (base build) or cycle 4 (EARLY_EXIT_EN).
- a=0xFFFFFFFF, b=0xFFFFFFFF → resp_msg=0x00000001.
- a=0x80000000, b=2 → resp_msg=0x00000000 (overflow wraps).
- resp_rdy held 0 for 10 cycles after DONE:
  - resp_val stays 1 and resp_msg stays constant.
  - A req_val during this time is not accepted (req_rdy=0).
- cancel pulsed in CALC cycle 10:
  - Next cycle is IDLE with req_rdy=1.
  - No resp_val for the squashed operation.
  - A following a=7, b=6 returns 42.
- Back-to-back requests 2×3 then 4×5 with resp_rdy=1:
  - Responses are 6 then 20, in order.
  - The second is accepted the cycle after the first response handshake.
- Reset asserted in CALC cycle 5 → resp_val=0 and req_rdy=0 immediately, with no response after release.
